// File: rtl/hex_page_display_if.sv
// Bus between the decrypt control and the paged hex display stage.
// load is a level "block valid" captured on its rising edge; page_adv is a one-cycle pulse.
interface hex_page_display_if;
    logic [63:0] data_in;
    logic        load;
    logic        page_adv;
    logic [6:0]  seven;
    logic [3:0]  EN;
    logic [1:0]  page;
    logic        valid;

    modport master (
        output data_in, load, page_adv,
        input  seven, EN, page, valid
    );

    modport slave (
        input  data_in, load, page_adv,
        output seven, EN, page, valid
    );
endinterface

// File: rtl/hex_page_display.sv
// Captures a 64-bit decrypted block and shows it four hex digits per page
// on a 4-digit multiplexed, active-low seven-segment display.
module hex_page_display #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    hex_page_display_if.slave  bus
);
    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [6:0] DASH = 7'b1111110;

    logic          load_d;
    logic [63:0]   data_reg;
    logic          valid_q;
    logic [1:0]    page_q;
    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit;
    logic [1:0]    digit_nxt;
    logic          cap;
    logic          tick;
    logic [15:0]   window;
    logic [3:0]    nibble;
    logic [6:0]    seven_nxt;
    logic [3:0]    en_nxt;
    logic [6:0]    seven_q;
    logic [3:0]    en_q;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b0000001;
            4'h1: hex_glyph = 7'b1001111;
            4'h2: hex_glyph = 7'b0010010;
            4'h3: hex_glyph = 7'b0000110;
            4'h4: hex_glyph = 7'b1001100;
            4'h5: hex_glyph = 7'b0100100;
            4'h6: hex_glyph = 7'b0100000;
            4'h7: hex_glyph = 7'b0001111;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0000100;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b1100000;
            4'hC: hex_glyph = 7'b0110001;
            4'hD: hex_glyph = 7'b1000010;
            4'hE: hex_glyph = 7'b0110000;
            default: hex_glyph = 7'b0111000;
        endcase
    endfunction

    assign cap       = bus.load & ~load_d;
    assign tick      = (refresh_cnt == CNT_LAST);
    assign digit_nxt = tick ? digit + 2'd1 : digit;

    // seven and EN are both built from digit_nxt so they register in lockstep with digit.
    always_comb begin
        case (page_q)
            2'd0:    window = data_reg[63:48];
            2'd1:    window = data_reg[47:32];
            2'd2:    window = data_reg[31:16];
            default: window = data_reg[15:0];
        endcase
        case (digit_nxt)
            2'd0:    nibble = window[3:0];
            2'd1:    nibble = window[7:4];
            2'd2:    nibble = window[11:8];
            default: nibble = window[15:12];
        endcase
        seven_nxt = valid_q ? hex_glyph(nibble) : DASH;
        en_nxt    = ~(4'b0001 << digit_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            load_d      <= 1'b0;
            data_reg    <= 64'h0;
            valid_q     <= 1'b0;
            page_q      <= 2'd0;
            refresh_cnt <= '0;
            digit       <= 2'd0;
            seven_q     <= DASH;
            en_q        <= 4'b1110;
        end else begin
            load_d      <= bus.load;
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            digit       <= digit_nxt;
            seven_q     <= seven_nxt;
            en_q        <= en_nxt;
            if (cap) begin
                data_reg <= bus.data_in;
                valid_q  <= 1'b1;
                page_q   <= 2'd0;
            end else if (bus.page_adv && valid_q) begin
                page_q   <= page_q + 2'd1;
            end
        end
    end

    assign bus.seven = seven_q;
    assign bus.EN    = en_q;
    assign bus.page  = page_q;
    assign bus.valid = valid_q;
endmodule

// File: doc/hex_page_display.md
# hex_page_display

Output stage after the DES decrypt path. It captures the 64-bit decrypted block when the block is flagged valid and shows it as 16 hex digits on the 4-digit multiplexed seven-segment display, four digits per page. The user steps through the 4 pages with the debounced second push-button pulse. This block replaces the ad-hoc page FSM and counter pair that currently sits downstream of the decrypt core.

## Interface
- `REFRESH_CYCLES`, default 50000: clock cycles each digit stays lit before the scan moves on. Must be at least 2.
- `clk`: input, 1 bit. The only clock. All logic is on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-low.
- `data_in`: input, 64 bits, [63:0]. Decrypted block. Bit 63 is the most significant nibble's MSB.
- `load`: input, 1 bit. Level "block valid" from the decrypt control. It is captured on its 0→1 transition.
- `page_adv`: input, 1 bit. Single-cycle pulse from the button edge detector. Advances the page.
- `seven`: output, 7 bits. Active-low segments, `{a,b,c,d,e,f,g}` = `seven[6:0]`. So '0' = 7'b0000001 and '1' = 7'b1001111.
- `EN`: output, 4 bits. Active-low digit anodes. `EN[3]` is the leftmost digit.
- `page`: output, 2 bits. Current page index.
- `valid`: output, 1 bit. High once a block has been captured.

## Operation
Edge detect on `load`:
- Register `load_d`.
- `cap = load & ~load_d`.
- On `cap`: `data_reg <= data_in`, `valid <= 1`, `page <= 0`.
- A level held high captures exactly once. To reload, `load` must go low and then high again.

Page counter:
- On `page_adv` (and no `cap`), `page <= page + 1` mod 4, so 3→0 wraps.
- `page_adv` is ignored while `valid` = 0; `page` stays 0.
- If `cap` and `page_adv` occur in the same cycle, `cap` wins and `page` = 0.

Digit mapping for page p:
- Window is `data_reg[63-16p -: 16]`.
- Digit 3 (`EN[3]`) shows the window's bits [15:12], down to digit 0 showing bits [3:0].
- So page 0 shows nibbles 15..12 of the block and page 3 shows nibbles 3..0.

Scan:
- `refresh_cnt` counts 0 .. `REFRESH_CYCLES`-1.
- At the terminal count it returns to 0 and `digit` (2 bits) increments mod 4.
- `EN` is the one-hot-low decode of `digit`: digit 0 → 4'b1110, digit 3 → 4'b0111.

Decode:
- Full hex table 0–F.
- A=7'b0001000, b=7'b1100000, C=7'b0110001, d=7'b1000010, E=7'b0110000, F=7'b0111000.
- While `valid` = 0, every digit shows dash 7'b1111110.

`seven` and `EN` are registered and always computed from the same `digit` value, so they are never skewed against each other.

## Timing
Reset (`rst` = 0 sampled at an edge), values from the next cycle:
- `seven` = 7'b1111110
- `EN` = 4'b1110
- `page` = 0
- `valid` = 0
- `data_reg` = 0, `load_d` = 0, `refresh_cnt` = 0, `digit` = 0

Reset mid-operation (capture in progress, or partway through a scan) discards all state. A `load` that is still high when reset releases counts as a rising edge.

Capture latency:
- `cap` is evaluated at edge N, when `load` = 1 and `load_d` = 0.
- `data_reg`, `valid` and `page` update at edge N.
- `seven` reflects the new data from edge N+1.

Page latency: `page_adv` sampled at edge N updates `page` at N; `seven` changes at N+1.

Scan period: each digit is lit for exactly `REFRESH_CYCLES` cycles, so a full frame is 4×`REFRESH_CYCLES` cycles. Capture and paging do not reset the scan.

`data_in` only needs to be stable during the capture cycle; later changes are ignored.

## Test plan
All scenarios use `REFRESH_CYCLES` = 4.
- **Reset.** Hold `rst` low for 3 cycles, then release. Expect `seven` = 7'b1111110, `EN` = 4'b1110, `page` = 0, `valid` = 0. `EN` must step through 1110→1101→1011→0111→1110, with 4 cycles per step.
- **Capture and page 0.** Apply `data_in` = 64'h0123456789ABCDEF with a `load` rise. Expect `valid` = 1 the next cycle. On page 0, `EN[3]` shows '0' (0000001), `EN[2]` '1', `EN[1]` '2', `EN[0]` '3'. Keep `load` high for 20 cycles with a changed `data_in`: no recapture.
- **Paging and wrap.** Send 4 `page_adv` pulses.
  - Page 1 shows 4567.
  - Page 2 shows 89Ab: `EN[0]` digit = 7'b1100000.
  - Page 3 shows CdEF.
  - The 4th pulse returns to page 0 (0123).
- **Simultaneous events.** On page 2, assert a `page_adv` pulse in the same cycle as a `load` rise with 64'hFFFF_0000_0000_0000. Expect `page` = 0 and all four digits = F (7'b0111000).
- **Pre-capture paging.** After reset, send `page_adv` pulses with no load. Expect `page` stays 0 and dashes persist.
- **Reset mid-scan.** Assert `rst` low during digit 2 after a capture. Expect all reset values, and a subsequent `load` rise recaptures correctly.
